// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS CPU: sequences IF/ID/EX/MEM/WB and drives every datapath select.
// Latency: outputs are combinational from state; lw 5, R/sw/addi/ori 4, beq/j 3 cycles, plus one per memory wait.
// Backpressure: IF, MRD and MWR hold while mem_ready is low; outputs are forced to 0 while rst_n is low.
module mc_ctrl_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REXE = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IEXE = 4'd10,
        S_IWB  = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_rdy;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic [1:0] w_pc_source;
    logic [1:0] w_alu_op;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_illegal_op;

    assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IF;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next          = S_IF;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_pc_source     = 2'b00;
        w_alu_op        = 2'b00;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_illegal_op    = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = w_rdy;
                w_pc_write  = w_rdy;
                w_next      = w_rdy ? S_ID : S_IF;
            end
            S_ID: begin
                // ALUOut captures PC+4 + (imm<<2) as a speculative branch target
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     w_next = S_MADR;
                    OP_R:             w_next = S_REXE;
                    OP_BEQ:           w_next = S_BR;
                    OP_J:             w_next = S_JMP;
                    OP_ADDI, OP_ORI:  w_next = S_IEXE;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next       = S_IF;
                    end
                endcase
            end
            S_MADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = w_rdy ? S_MWB : S_MRD;
            end
            S_MWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                w_next      = w_rdy ? S_IF : S_MWR;
            end
            S_REXE: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
                w_next      = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BR: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            S_JMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
            S_IEXE: begin
                w_alu_src_a = 1'b1;
                if (opcode == OP_ORI) begin
                    w_alu_src_b = 2'b11;
                    w_alu_op    = 2'b11;
                end else begin
                    w_alu_src_b = 2'b10;
                end
                w_next = S_IWB;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

    // Gating with rst_n kills any in-flight write the moment reset asserts
    assign pc_write      = rst_n & w_pc_write;
    assign pc_write_cond = rst_n & w_pc_write_cond;
    assign i_or_d        = rst_n & w_i_or_d;
    assign mem_read      = rst_n & w_mem_read;
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign mem_to_reg    = rst_n & w_mem_to_reg;
    assign pc_source     = {2{rst_n}} & w_pc_source;
    assign alu_op        = {2{rst_n}} & w_alu_op;
    assign alu_src_a     = rst_n & w_alu_src_a;
    assign alu_src_b     = {2{rst_n}} & w_alu_src_b;
    assign reg_write     = rst_n & w_reg_write;
    assign reg_dst       = rst_n & w_reg_dst;
    assign illegal_op    = rst_n & w_illegal_op;
    assign state         = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, hand-written branch/immediate sequence,
// then randomized run against an instruction-level reference model.
module tb_mc_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic       mr, mw, rw, irw, ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, illegal_op;
    logic [3:0] state;
    out_t       act;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .illegal_op(illegal_op), .state(state)
    );

    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    endfunction

    // Expected datapath controls for a state, straight from the control table
    function automatic out_t model_out(input int st, input logic [5:0] op, input logic rdy);
        out_t o;
        o = '0;
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op); end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.i_or_d = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.mem_write = 1; o.i_or_d = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin
                o.alu_src_a = 1;
                if (op == OP_ORI) begin o.alu_src_b = 2'b11; o.alu_op = 2'b11; end
                else              o.alu_src_b = 2'b10;
            end
            11: o.reg_write = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Post-fetch step list of one instruction (IF itself excluded)
    function automatic void build_path(input logic [5:0] op, output int p[$]);
        p = {};
        case (op)
            OP_LW:           p = '{1, 2, 3, 4};
            OP_SW:           p = '{1, 2, 5};
            OP_R:            p = '{1, 6, 7};
            OP_BEQ:          p = '{1, 8};
            OP_J:            p = '{1, 9};
            OP_ADDI, OP_ORI: p = '{1, 10, 11};
            default:         p = '{1};
        endcase
    endfunction

    vec_t       tbl[$];
    int         m_state;
    int         path[$];
    logic [5:0] ops[7];
    logic [5:0] cur_op;
    out_t       exp_o;

    task automatic v(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic mr, input logic mw, input logic rw, input logic irw, input logic ill);
        vec_t e;
        e.rst_n = r; e.op = op; e.rdy = rdy; e.st = st;
        e.mr = mr; e.mw = mw; e.rw = rw; e.irw = irw; e.ill = ill;
        tbl.push_back(e);
    endtask

    initial begin
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
        rst_n = 1'b0; opcode = OP_LW; mem_ready = 1'b1;

        //  rst op      rdy st  mr mw rw irw ill
        v(0, OP_LW,  1, 0,  0, 0, 0, 0, 0);
        v(0, OP_LW,  1, 0,  0, 0, 0, 0, 0);
        v(0, OP_LW,  1, 0,  0, 0, 0, 0, 0);
        v(1, OP_LW,  1, 0,  1, 0, 0, 1, 0);
        v(1, OP_LW,  1, 1,  0, 0, 0, 0, 0);
        v(1, OP_LW,  1, 2,  0, 0, 0, 0, 0);
        v(1, OP_LW,  1, 3,  1, 0, 0, 0, 0);
        v(1, OP_LW,  1, 4,  0, 0, 1, 0, 0);
        v(1, OP_SW,  1, 0,  1, 0, 0, 1, 0);
        v(1, OP_SW,  1, 1,  0, 0, 0, 0, 0);
        v(1, OP_SW,  1, 2,  0, 0, 0, 0, 0);
        v(1, OP_SW,  0, 5,  0, 1, 0, 0, 0);
        v(1, OP_SW,  0, 5,  0, 1, 0, 0, 0);
        v(1, OP_SW,  1, 5,  0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(1, OP_J, 0, 0, 1, 0, 0, 0, 0);
        v(1, OP_J,   1, 0,  1, 0, 0, 1, 0);
        v(1, OP_J,   1, 1,  0, 0, 0, 0, 0);
        v(1, OP_J,   1, 9,  0, 0, 0, 0, 0);
        v(1, OP_ILL, 1, 0,  1, 0, 0, 1, 0);
        v(1, OP_ILL, 1, 1,  0, 0, 0, 0, 1);
        v(1, OP_SW,  1, 0,  1, 0, 0, 1, 0);
        v(1, OP_SW,  1, 1,  0, 0, 0, 0, 0);
        v(1, OP_SW,  1, 2,  0, 0, 0, 0, 0);
        v(1, OP_SW,  0, 5,  0, 1, 0, 0, 0);
        v(0, OP_SW,  0, 0,  0, 0, 0, 0, 0);
        v(1, OP_LW,  1, 0,  1, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; opcode = tbl[i].op; mem_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {state, mem_read, mem_write, reg_write, ir_write, illegal_op},
                {tbl[i].st, tbl[i].mr, tbl[i].mw, tbl[i].rw, tbl[i].irw, tbl[i].ill});
            if (!tbl[i].rst_n) chk($sformatf("vec%0d_rst_outs", i), act, 0);
            cyc();
        end

        rst_n = 1'b0; cyc(); rst_n = 1'b1;

        // beq then ori, checked field by field
        opcode = OP_BEQ; mem_ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("beq_state", state, 8);
        chk("beq_pwc_aluop_psrc", {pc_write_cond, alu_op, pc_source}, 5'b1_01_01);
        cyc();
        opcode = OP_ORI;
        @(negedge clk);
        chk("beq_back_to_if", state, 0);
        cyc(); cyc();
        @(negedge clk);
        chk("ori_iexe", {state, alu_op, alu_src_b, alu_src_a}, {4'd10, 2'b11, 2'b11, 1'b1});
        cyc();
        @(negedge clk);
        chk("ori_iwb", {state, reg_write, reg_dst}, {4'd11, 1'b1, 1'b0});
        cyc();

        m_state = 0; path = {}; cur_op = OP_R;
        for (int c = 0; c < 3000; c++) begin
            if (m_state == 0)
                cur_op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            opcode    = cur_op;
            mem_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            @(negedge clk);
            exp_o = rst_n ? model_out(m_state, opcode, mem_ready) : '0;
            chk($sformatf("rnd%0d_outs", c), act, exp_o);
            chk($sformatf("rnd%0d_state", c), state, rst_n ? m_state : 0);
            @(posedge clk);
            if (!rst_n) begin
                m_state = 0; path = {};
            end else if (m_state == 0) begin
                if (mem_ready) begin
                    build_path(opcode, path);
                    m_state = path.pop_front();
                end
            end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
                m_state = m_state;
            end else begin
                m_state = (path.size() > 0) ? path.pop_front() : 0;
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
